pb_irq_ctrl: RTL and testbench
==============================

PB_IRQ_CTRL -- requirements
Module: pb_irq_ctrl

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 8'h10, which is the PicoBlaze port_id of register 0; registers occupy BASE_ADDR..BASE_ADDR+2.
REQ-002 SHALL have parameter SYNC_IRQ, default 1, which adds a 2-flop synchronizer on irq_i when set to 1 and bypasses it when set to 0.
REQ-003 SHALL have port clk, input, 1 bit: single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port irq_i, input, 8 bits: interrupt sources; bit 0 is highest priority.
REQ-006 SHALL have port port_id, input, 8 bits: PicoBlaze I/O address.
REQ-007 SHALL have port out_port, input, 8 bits: PicoBlaze write data.
REQ-008 SHALL have port write_strobe, input, 1 bit: PicoBlaze OUTPUT strobe.
REQ-009 SHALL have port read_strobe, input, 1 bit: PicoBlaze INPUT strobe.
REQ-010 SHALL have port in_port, output, 8 bits: registered read data.
REQ-011 SHALL have port interrupt_o, output, 1 bit: drives the CPU interrupt input.
REQ-012 SHALL have port interrupt_ack_i, input, 1 bit: PicoBlaze interrupt_ack.
REQ-013 SHALL have port int_src, output, 3 bits: index of the source currently in service.

Function
REQ-014 SHALL detect rising edges on each irq_i bit, after synchronization when SYNC_IRQ=1, by comparison with the previous-cycle value.
REQ-015 SHALL set PENDING[n] in the cycle after a rising edge is detected on source n.
REQ-016 SHALL provide register map: BASE+0 PENDING, read / write-1-to-clear; BASE+1 MASK, read/write, 1 = enabled; BASE+2 VECTOR, read-only, {valid, 4'b0, int_src}.
REQ-017 SHALL give set priority over clear when a W1C write and a new edge hit the same PENDING bit in the same cycle; the bit remains 1.
REQ-018 SHALL update in_port one cycle after port_id is presented, whether or not read_strobe is asserted.
REQ-019 SHALL drive in_port to 8'h00 when port_id does not decode to a register.
REQ-020 SHALL ignore write_strobe when port_id does not decode to a writable register; reads have no side effects.
REQ-021 SHALL implement FSM state IDLE: interrupt_o=0; move to REQ when (PENDING & MASK) != 0.
REQ-022 SHALL implement FSM state REQ: interrupt_o=1; on interrupt_ack_i, latch int_src as the lowest set index of PENDING & MASK at that cycle, set valid, and move to SERVICE.
REQ-023 SHALL implement FSM state REQ so that if PENDING & MASK becomes 0 before interrupt_ack_i, it returns to IDLE and drops interrupt_o.
REQ-024 SHALL implement FSM state SERVICE: interrupt_o=0; stay until PENDING[int_src] is cleared, then clear valid and move to IDLE.
REQ-025 SHALL not pre-empt service: higher-priority edges arriving during SERVICE only set PENDING.
REQ-026 SHALL let a MASK write in SERVICE alter the selection for the next REQ only; the current int_src is unaffected.
REQ-027 SHALL take at most 2 clk cycles from a PENDING bit becoming enabled to interrupt_o=1.
REQ-028 SHALL ignore interrupt_ack_i in IDLE and SERVICE.

Reset
REQ-029 SHALL apply the following values on rst=1 at the next clk edge: PENDING=0, MASK=0, int_src=0, valid=0, in_port=0, interrupt_o=0, FSM=IDLE, edge and synchronizer history=0.
REQ-030 SHALL hold all of the above values while rst=1.
REQ-031 SHALL not produce a pending bit after rst deasserts from a source that was already high during reset.
REQ-032 SHALL abandon any REQ or SERVICE in progress when rst asserts mid-operation, with no residual interrupt_o.

Verification
REQ-033 SHALL pass this test: MASK=8'h04, then pulse irq_i[2] -> interrupt_o=1 within 2 cycles (after synchronizer delay); pulse ack -> int_src=2, VECTOR=8'h82; write 8'h04 to BASE+0 -> FSM returns to IDLE and VECTOR=8'h02.
REQ-034 SHALL pass this test: MASK=8'hFF, edges on bits 5 and 1 in the same cycle -> ack gives int_src=1; clearing bit 1 leads to a new REQ with int_src=5 after ack.
REQ-035 SHALL pass this test: MASK=8'h00, edge on bit 3 -> PENDING=8'h08 and interrupt_o stays 0; writing MASK=8'h08 -> interrupt_o=1.
REQ-036 SHALL pass this test: W1C of bit 4 in the same cycle as a bit-4 edge -> PENDING[4] remains 1.
REQ-037 SHALL pass this test: irq_i held high across reset release -> PENDING stays 0; rst asserted in SERVICE -> all outputs 0 next cycle.
REQ-038 SHALL pass this test: read port_id=BASE+7 -> in_port=8'h00; write to BASE+2 -> no state change.

Source files
------------

// File: rtl/pb_irq_ctrl.sv
// PicoBlaze interrupt controller: edge-detected sources, W1C pending/mask registers,
// and a request/acknowledge/service sequencer presenting the serviced source index.
module pb_irq_ctrl #(
   parameter logic [7:0] BASE_ADDR = 8'h10,
   parameter int         SYNC_IRQ  = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] irq_i,
   input  logic [7:0] port_id,
   input  logic [7:0] out_port,
   input  logic       write_strobe,
   input  logic       read_strobe,
   output logic [7:0] in_port,
   output logic       interrupt_o,
   input  logic       interrupt_ack_i,
   output logic [2:0] int_src
);

   typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

   localparam logic [7:0] ADDR_PEND = BASE_ADDR;
   localparam logic [7:0] ADDR_MASK = BASE_ADDR + 8'd1;
   localparam logic [7:0] ADDR_VEC  = BASE_ADDR + 8'd2;

   // Clocks after reset until the edge history holds real samples of irq_i.
   localparam logic [1:0] SETTLE = (SYNC_IRQ == 1) ? 2'd3 : 2'd1;

   state_t     state;
   logic [7:0] irq_sync;
   logic [7:0] irq_prev;
   logic [7:0] irq_rise;
   logic [1:0] settle_cnt;
   logic       edge_en;
   logic [7:0] pending;
   logic [7:0] mask;
   logic [7:0] enabled;
   logic [7:0] w1c;
   logic [7:0] vector;
   logic       valid;
   logic       wr_pend;
   logic       wr_mask;
   logic       unused_rd;

   function automatic logic [2:0] lowest_idx(input logic [7:0] v);
      lowest_idx = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (v[i]) lowest_idx = i[2:0];
      end
   endfunction

   generate
      if (SYNC_IRQ == 1) begin : g_sync
         logic [7:0] irq_p0;
         logic [7:0] irq_p1;
         // Synchronizer stage p0 -> p1
         always_ff @(posedge clk) begin
            if (rst) begin
               irq_p0 <= 8'h00;
               irq_p1 <= 8'h00;
            end else begin
               irq_p0 <= irq_i;
               irq_p1 <= irq_p0;
            end
         end
         assign irq_sync = irq_p1;
      end else begin : g_nosync
         assign irq_sync = irq_i;
      end
   endgenerate

   // Edges are suppressed until the history is primed, so a source already high
   // during reset does not look like a fresh edge when reset releases.
   assign edge_en  = (settle_cnt == SETTLE);
   assign irq_rise = edge_en ? (irq_sync & ~irq_prev) : 8'h00;

   always_ff @(posedge clk) begin
      if (rst) begin
         settle_cnt <= 2'd0;
         irq_prev   <= 8'h00;
      end else begin
         if (!edge_en) settle_cnt <= settle_cnt + 2'd1;
         irq_prev <= irq_sync;
      end
   end

   assign wr_pend   = write_strobe && (port_id == ADDR_PEND);
   assign wr_mask   = write_strobe && (port_id == ADDR_MASK);
   assign w1c       = wr_pend ? out_port : 8'h00;
   assign enabled   = pending & mask;
   assign vector    = {valid, 4'b0000, int_src};
   // Read data follows port_id alone; the strobe has no side effects here.
   assign unused_rd = read_strobe;

   // Set wins over a simultaneous write-1-to-clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         pending <= 8'h00;
         mask    <= 8'h00;
      end else begin
         pending <= (pending & ~w1c) | irq_rise;
         if (wr_mask) mask <= out_port;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         in_port <= 8'h00;
      end else begin
         case (port_id)
            ADDR_PEND: in_port <= pending;
            ADDR_MASK: in_port <= mask;
            ADDR_VEC:  in_port <= vector;
            default:   in_port <= 8'h00;
         endcase
      end
   end

   // int_src is held after service ends so VECTOR keeps reporting the last source.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         interrupt_o <= 1'b0;
         int_src     <= 3'd0;
         valid       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (enabled != 8'h00) begin
                  state       <= REQ;
                  interrupt_o <= 1'b1;
               end
            end
            REQ: begin
               if (enabled == 8'h00) begin
                  state       <= IDLE;
                  interrupt_o <= 1'b0;
               end else if (interrupt_ack_i) begin
                  int_src     <= lowest_idx(enabled);
                  valid       <= 1'b1;
                  interrupt_o <= 1'b0;
                  state       <= SERVICE;
               end
            end
            SERVICE: begin
               if (!pending[int_src]) begin
                  valid <= 1'b0;
                  state <= IDLE;
               end
            end
            default: begin
               state       <= IDLE;
               interrupt_o <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pb_irq_ctrl.sv
// Self-checking bench for pb_irq_ctrl: register reads are scored against a queue of
// expected values pushed when each read is issued.
module tb_pb_irq_ctrl;

   localparam logic [7:0] BASE = 8'h10;

   logic       clk;
   logic       rst;
   logic [7:0] irq_i;
   logic [7:0] port_id;
   logic [7:0] out_port;
   logic       write_strobe;
   logic       read_strobe;
   logic [7:0] in_port;
   logic       interrupt_o;
   logic       interrupt_ack_i;
   logic [2:0] int_src;

   int n_chk  = 0;
   int n_fail = 0;
   logic [7:0] sb[$];

   pb_irq_ctrl #(.BASE_ADDR(BASE), .SYNC_IRQ(1)) dut (
      .clk(clk), .rst(rst), .irq_i(irq_i), .port_id(port_id), .out_port(out_port),
      .write_strobe(write_strobe), .read_strobe(read_strobe), .in_port(in_port),
      .interrupt_o(interrupt_o), .interrupt_ack_i(interrupt_ack_i), .int_src(int_src)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [7:0] addr, input logic [7:0] data);
      port_id      = addr;
      out_port     = data;
      write_strobe = 1'b1;
      tick();
      write_strobe = 1'b0;
   endtask

   task automatic rd(input string tag, input logic [7:0] addr, input logic [7:0] exp);
      logic [7:0] e;
      sb.push_back(exp);
      port_id     = addr;
      read_strobe = 1'b1;
      tick();
      read_strobe = 1'b0;
      if (sb.size() == 0) begin
         check({tag, "_sb_empty"}, 8'h01, 8'h00);
      end else begin
         e = sb.pop_front();
         check(tag, in_port, e);
      end
   endtask

   task automatic pulse(input logic [7:0] m);
      irq_i = m;
      tick();
      irq_i = 8'h00;
   endtask

   task automatic wait_irq(input string tag, input int max);
      int n = 0;
      while (!interrupt_o && n < max) begin
         tick();
         n++;
      end
      check(tag, {7'd0, interrupt_o}, 8'h01);
   endtask

   task automatic ack();
      interrupt_ack_i = 1'b1;
      tick();
      interrupt_ack_i = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; irq_i = 8'h40; port_id = BASE; out_port = 8'h00;
      write_strobe = 1'b0; read_strobe = 1'b0; interrupt_ack_i = 1'b0;
      repeat (4) tick();
      check("rst_in_port", in_port, 8'h00);
      check("rst_irq", {7'd0, interrupt_o}, 8'h00);
      check("rst_src", {5'd0, int_src}, 8'h00);

      // Source high across reset release must not become pending
      rst = 1'b0;
      repeat (6) tick();
      rd("hold_high_pend", BASE, 8'h00);
      check("hold_high_irq", {7'd0, interrupt_o}, 8'h00);
      irq_i = 8'h00;
      repeat (2) tick();

      // Single source through request, ack, service and clear
      wr(BASE + 8'd1, 8'h04);
      pulse(8'h04);
      wait_irq("t1_req", 8);
      ack();
      check("t1_src", {5'd0, int_src}, 8'h02);
      check("t1_irq_low", {7'd0, interrupt_o}, 8'h00);
      rd("t1_vec", BASE + 8'd2, 8'h82);
      wr(BASE, 8'h04);
      tick();
      rd("t1_vec_done", BASE + 8'd2, 8'h02);
      check("t1_idle", {7'd0, interrupt_o}, 8'h00);

      // Simultaneous edges: lowest index first, the other follows
      wr(BASE + 8'd1, 8'hFF);
      pulse(8'h22);
      wait_irq("t2_req", 8);
      ack();
      check("t2_src1", {5'd0, int_src}, 8'h01);
      rd("t2_pend", BASE, 8'h22);
      wr(BASE, 8'h02);
      wait_irq("t2_req2", 8);
      ack();
      check("t2_src5", {5'd0, int_src}, 8'h05);
      wr(BASE, 8'h20);
      repeat (2) tick();
      check("t2_idle", {7'd0, interrupt_o}, 8'h00);
      rd("t2_pend_clr", BASE, 8'h00);

      // Masked source stays pending until enabled
      wr(BASE + 8'd1, 8'h00);
      pulse(8'h08);
      repeat (5) tick();
      check("t3_masked", {7'd0, interrupt_o}, 8'h00);
      rd("t3_pend", BASE, 8'h08);
      wr(BASE + 8'd1, 8'h08);
      wait_irq("t3_req", 3);
      ack();
      check("t3_src", {5'd0, int_src}, 8'h03);
      wr(BASE, 8'h08);
      repeat (2) tick();

      // W1C in the same cycle as a new edge: set wins
      wr(BASE + 8'd1, 8'h00);
      irq_i = 8'h10;
      tick();
      tick();
      wr(BASE, 8'h10);
      rd("t4_set_wins", BASE, 8'h10);
      wr(BASE, 8'h10);
      rd("t4_w1c", BASE, 8'h00);
      irq_i = 8'h00;

      // Undecoded read and write to the read-only register
      wr(BASE + 8'd1, 8'h5A);
      wr(BASE + 8'd2, 8'hFF);
      wr(8'h20, 8'hFF);
      rd("t5_undecoded", BASE + 8'd7, 8'h00);
      rd("t5_below", BASE - 8'd1, 8'h00);
      rd("t5_mask", BASE + 8'd1, 8'h5A);
      rd("t5_pend", BASE, 8'h00);
      rd("t5_vec", BASE + 8'd2, 8'h03);

      // Request withdrawn before ack
      wr(BASE + 8'd1, 8'h01);
      pulse(8'h01);
      wait_irq("t6_req", 8);
      wr(BASE, 8'h01);
      tick();
      check("t6_withdraw", {7'd0, interrupt_o}, 8'h00);
      ack();
      rd("t6_ack_idle", BASE + 8'd2, 8'h03);

      // Reset during service
      wr(BASE + 8'd1, 8'h40);
      pulse(8'h40);
      wait_irq("t7_req", 8);
      ack();
      check("t7_src", {5'd0, int_src}, 8'h06);
      port_id = BASE + 8'd2;
      rst = 1'b1;
      tick();
      check("t7_rst_irq", {7'd0, interrupt_o}, 8'h00);
      check("t7_rst_src", {5'd0, int_src}, 8'h00);
      check("t7_rst_in", in_port, 8'h00);
      repeat (2) tick();
      rst = 1'b0;
      repeat (4) tick();
      rd("t7_vec", BASE + 8'd2, 8'h00);
      rd("t7_mask", BASE + 8'd1, 8'h00);
      rd("t7_pend", BASE, 8'h00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
